// File: rtl/core_pkg.sv
// Shared types and sizing for the branch-tag allocator / mispredict recovery stage.
package core_pkg;

  localparam int N_BR_TAGS = 8;
  localparam int TAG_W     = $clog2(N_BR_TAGS);
  localparam int ROB_IDX_W = 6;
  localparam int XLEN      = 32;

  typedef logic [TAG_W-1:0] br_tag_t;
  // Queue pointer: tag index plus a wrap bit so full and empty can be told apart.
  typedef logic [TAG_W:0]   br_ptr_t;

  typedef enum logic [1:0] {BR_FREE, BR_PEND, BR_OK} br_state_e;
  typedef enum logic [0:0] {BR_IDLE, BR_FLUSH}        br_fsm_e;

  typedef struct packed {
    br_state_e            state;
    logic [ROB_IDX_W-1:0] rob_idx;
  } br_entry_t;

  function automatic br_tag_t tag_age(input br_tag_t t, input br_tag_t head);
    return br_tag_t'(t - head);
  endfunction

endpackage

// File: rtl/br_age_cmp.sv
// Age compare relative to the queue head: liveness of tag_a and relative age of tag_a vs tag_b.
module br_age_cmp
  import core_pkg::*;
(
  input  br_tag_t head_i,
  input  br_ptr_t count_i,
  input  br_tag_t tag_a_i,
  input  br_tag_t tag_b_i,
  output logic    live_a_o,
  output logic    a_older_b_o
);

  br_tag_t age_a;
  br_tag_t age_b;

  always_comb begin
    age_a       = tag_age(tag_a_i, head_i);
    age_b       = tag_age(tag_b_i, head_i);
    live_a_o    = {1'b0, age_a} < count_i;
    a_older_b_o = age_a < age_b;
  end

endmodule

// File: rtl/br_resolve_unit.sv
// Branch-tag allocator with out-of-order resolution, in-order commit and
// single-pulse flush/redirect on a mispredict.
//
// state    | meaning
// BR_IDLE  | normal operation, allocation allowed
// BR_FLUSH | redirect/flush pulse driven this cycle, allocation blocked
module br_resolve_unit
  import core_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_req_i,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx_i,
  output logic                 alloc_ready_o,
  output br_tag_t              alloc_tag_o,
  input  logic                 beu_valid_i,
  input  br_tag_t              beu_tag_i,
  input  logic                 beu_mispred_i,
  input  logic [XLEN-1:0]      beu_target_i,
  input  logic                 commit_br_i,
  output logic                 redirect_valid_o,
  output logic [XLEN-1:0]      redirect_pc_o,
  output logic                 flush_valid_o,
  output br_tag_t              flush_tag_o,
  output logic [ROB_IDX_W-1:0] flush_rob_idx_o,
  output logic                 empty_o
);

  localparam br_ptr_t PTR_ONE = br_ptr_t'(1);

  br_entry_t            entry_q [N_BR_TAGS];
  br_entry_t            entry_d [N_BR_TAGS];
  br_ptr_t              head_q, head_d;
  br_ptr_t              tail_q, tail_d;
  br_fsm_e              fsm_q, fsm_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  br_tag_t              ftag_q, ftag_d;
  logic [ROB_IDX_W-1:0] frob_q, frob_d;

  br_ptr_t count;
  br_tag_t head_idx;
  br_tag_t tail_idx;
  br_tag_t beu_age;
  logic    full;
  logic    empty;
  logic    beu_live;
  logic    beu_older;
  logic    beu_hit;
  logic    mis_take;
  logic    resolve_ok;
  logic    commit_ok;
  logic    alloc_fire;

  assign count    = tail_q - head_q;
  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign full     = count[TAG_W];
  assign empty    = (count == '0);
  assign beu_age  = tag_age(beu_tag_i, head_idx);

  br_age_cmp u_age_cmp (
    .head_i      (head_idx),
    .count_i     (count),
    .tag_a_i     (beu_tag_i),
    .tag_b_i     (ftag_q),
    .live_a_o    (beu_live),
    .a_older_b_o (beu_older)
  );

  // During FLUSH only a mispredict older than the one being flushed may preempt it.
  assign beu_hit    = beu_valid_i && beu_live && (entry_q[beu_tag_i].state == BR_PEND);
  assign mis_take   = beu_hit && beu_mispred_i && ((fsm_q == BR_IDLE) || beu_older);
  assign resolve_ok = beu_hit && (!beu_mispred_i || mis_take);
  assign commit_ok  = commit_br_i && !empty && (entry_q[head_idx].state == BR_OK);
  assign alloc_fire = alloc_req_i && alloc_ready_o;

  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pc_d    = pc_q;
    ftag_d  = ftag_q;
    frob_d  = frob_q;
    fsm_d   = mis_take ? BR_FLUSH : BR_IDLE;

    if (alloc_fire) begin
      entry_d[tail_idx] = '{state: BR_PEND, rob_idx: alloc_rob_idx_i};
      tail_d            = tail_q + PTR_ONE;
    end

    if (resolve_ok) entry_d[beu_tag_i].state = BR_OK;

    // Rewind frees everything younger, including a same-cycle allocation.
    if (mis_take) begin
      pc_d   = beu_target_i;
      ftag_d = beu_tag_i;
      frob_d = entry_q[beu_tag_i].rob_idx;
      tail_d = head_q + {1'b0, beu_age} + PTR_ONE;
      for (int i = 0; i < N_BR_TAGS; i++) begin
        if (tag_age(br_tag_t'(i), head_idx) > beu_age) entry_d[i].state = BR_FREE;
      end
    end

    if (commit_ok) begin
      entry_d[head_idx].state = BR_FREE;
      head_d                  = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BR_TAGS; i++) entry_q[i] <= '{state: BR_FREE, rob_idx: '0};
      head_q <= '0;
      tail_q <= '0;
      fsm_q  <= BR_IDLE;
      pc_q   <= '0;
      ftag_q <= '0;
      frob_q <= '0;
    end else begin
      for (int i = 0; i < N_BR_TAGS; i++) entry_q[i] <= entry_d[i];
      head_q <= head_d;
      tail_q <= tail_d;
      fsm_q  <= fsm_d;
      pc_q   <= pc_d;
      ftag_q <= ftag_d;
      frob_q <= frob_d;
    end
  end

  assign alloc_ready_o    = !full && (fsm_q == BR_IDLE);
  assign alloc_tag_o      = tail_idx;
  assign redirect_valid_o = (fsm_q == BR_FLUSH);
  assign flush_valid_o    = (fsm_q == BR_FLUSH);
  assign redirect_pc_o    = pc_q;
  assign flush_tag_o      = ftag_q;
  assign flush_rob_idx_o  = frob_q;
  assign empty_o          = empty;

  // Commit is only legal on a resolved head.
  commit_legal_a : assert property (@(posedge clk) disable iff (!rst_n)
    commit_br_i |-> (!empty && (entry_q[head_idx].state == BR_OK)));

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit; flush pulses are checked against a scoreboard queue.
module tb_br_resolve_unit;
  import core_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 alloc_req_i;
  logic [ROB_IDX_W-1:0] alloc_rob_idx_i;
  logic                 alloc_ready_o;
  br_tag_t              alloc_tag_o;
  logic                 beu_valid_i;
  br_tag_t              beu_tag_i;
  logic                 beu_mispred_i;
  logic [XLEN-1:0]      beu_target_i;
  logic                 commit_br_i;
  logic                 redirect_valid_o;
  logic [XLEN-1:0]      redirect_pc_o;
  logic                 flush_valid_o;
  br_tag_t              flush_tag_o;
  logic [ROB_IDX_W-1:0] flush_rob_idx_o;
  logic                 empty_o;

  typedef struct {
    logic [XLEN-1:0]      pc;
    br_tag_t              tag;
    logic [ROB_IDX_W-1:0] rob;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  br_resolve_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alloc_req_i      (alloc_req_i),
    .alloc_rob_idx_i  (alloc_rob_idx_i),
    .alloc_ready_o    (alloc_ready_o),
    .alloc_tag_o      (alloc_tag_o),
    .beu_valid_i      (beu_valid_i),
    .beu_tag_i        (beu_tag_i),
    .beu_mispred_i    (beu_mispred_i),
    .beu_target_i     (beu_target_i),
    .commit_br_i      (commit_br_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_valid_o    (flush_valid_o),
    .flush_tag_o      (flush_tag_o),
    .flush_rob_idx_o  (flush_rob_idx_o),
    .empty_o          (empty_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest expected flush.
  always @(negedge clk) begin
    if (rst_n && redirect_valid_o) begin
      chk("pulse_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("redirect_pc", 64'(redirect_pc_o), 64'(e.pc));
        chk("flush_tag", 64'(flush_tag_o), 64'(e.tag));
        chk("flush_rob_idx", 64'(flush_rob_idx_o), 64'(e.rob));
        chk("flush_valid", 64'(flush_valid_o), 64'd1);
      end
    end
  end

  task automatic idle_inputs();
    alloc_req_i     = 1'b0;
    alloc_rob_idx_i = '0;
    beu_valid_i     = 1'b0;
    beu_tag_i       = '0;
    beu_mispred_i   = 1'b0;
    beu_target_i    = '0;
    commit_br_i     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic alloc(input int rob);
    alloc_req_i     = 1'b1;
    alloc_rob_idx_i = ROB_IDX_W'(rob);
    tick();
  endtask

  task automatic beu(input int tag, input logic mis, input logic [XLEN-1:0] pc);
    beu_valid_i   = 1'b1;
    beu_tag_i     = br_tag_t'(tag);
    beu_mispred_i = mis;
    beu_target_i  = pc;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] pc, input int tag, input int rob);
    exp_t e;
    e.pc  = pc;
    e.tag = br_tag_t'(tag);
    e.rob = ROB_IDX_W'(rob);
    sb.push_back(e);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    do_reset();

    // Reset state
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_tag", 64'(alloc_tag_o), 64'd0);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_redirect", 64'(redirect_valid_o), 64'd0);
    chk("rst_flush", 64'(flush_valid_o), 64'd0);
    chk("rst_pc", 64'(redirect_pc_o), 64'd0);
    chk("rst_ftag", 64'(flush_tag_o), 64'd0);
    chk("rst_frob", 64'(flush_rob_idx_o), 64'd0);

    // 1: fill, refuse 9th alloc alongside commit, grant it next cycle
    for (int i = 0; i < 8; i++) begin
      chk("t1_ready", 64'(alloc_ready_o), 64'd1);
      chk("t1_tag", 64'(alloc_tag_o), 64'(i));
      alloc(i);
    end
    chk("t1_full_ready", 64'(alloc_ready_o), 64'd0);
    chk("t1_full_empty", 64'(empty_o), 64'd0);
    beu(0, 1'b0, '0);
    tick();
    alloc_req_i = 1'b1;
    alloc_rob_idx_i = 6'd8;
    commit_br_i = 1'b1;
    tick();
    chk("t1_refused_tag", 64'(alloc_tag_o), 64'd0);
    chk("t1_after_commit_ready", 64'(alloc_ready_o), 64'd1);
    alloc(8);
    chk("t1_granted_next", 64'(alloc_tag_o), 64'd1);
    chk("t1_full_again", 64'(alloc_ready_o), 64'd0);

    // 2: out-of-order OK resolutions, then drain
    do_reset();
    for (int i = 0; i < 4; i++) alloc(10 + i);
    beu(2, 1'b0, '0); tick();
    beu(0, 1'b0, '0); tick();
    beu(3, 1'b0, '0); tick();
    beu(1, 1'b0, '0); tick();
    chk("t2_no_pulse", 64'(redirect_valid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_not_empty", 64'(empty_o), 64'd0);
      commit_br_i = 1'b1;
      tick();
    end
    chk("t2_empty", 64'(empty_o), 64'd1);
    chk("t2_tail", 64'(alloc_tag_o), 64'd4);

    // 3: mispredict tag 1, late result for squashed tag 3 dropped
    do_reset();
    for (int i = 0; i < 5; i++) alloc(20 + i);
    beu(1, 1'b1, 32'h0000_1040);
    push_exp(32'h0000_1040, 1, 21);
    tick();
    chk("t3_pulse", 64'(redirect_valid_o), 64'd1);
    chk("t3_ready_flush", 64'(alloc_ready_o), 64'd0);
    chk("t3_rewound_tag", 64'(alloc_tag_o), 64'd2);
    beu(3, 1'b1, 32'hDEAD_0000);
    tick();
    chk("t3_single_pulse", 64'(redirect_valid_o), 64'd0);
    chk("t3_ready_idle", 64'(alloc_ready_o), 64'd1);
    chk("t3_alloc_tag", 64'(alloc_tag_o), 64'd2);
    beu(3, 1'b1, 32'hDEAD_0004);
    tick();
    chk("t3_stale_dropped", 64'(redirect_valid_o), 64'd0);

    // 4a: older mispredict during FLUSH gives back-to-back pulses
    do_reset();
    for (int i = 0; i < 5; i++) alloc(30 + i);
    beu(3, 1'b1, 32'h0000_3000);
    push_exp(32'h0000_3000, 3, 33);
    tick();
    chk("t4a_first_pulse", 64'(redirect_valid_o), 64'd1);
    beu(1, 1'b1, 32'h0000_2000);
    push_exp(32'h0000_2000, 1, 31);
    tick();
    chk("t4a_second_pulse", 64'(redirect_valid_o), 64'd1);
    chk("t4a_rewound_tag", 64'(alloc_tag_o), 64'd2);
    tick();
    chk("t4a_done", 64'(redirect_valid_o), 64'd0);
    chk("t4a_ready", 64'(alloc_ready_o), 64'd1);

    // 4b: younger mispredict during FLUSH dropped
    do_reset();
    for (int i = 0; i < 5; i++) alloc(30 + i);
    beu(3, 1'b1, 32'h0000_3000);
    push_exp(32'h0000_3000, 3, 33);
    tick();
    beu(4, 1'b1, 32'h0000_4000);
    tick();
    chk("t4b_single_pulse", 64'(redirect_valid_o), 64'd0);
    chk("t4b_tail", 64'(alloc_tag_o), 64'd4);

    // 5: wrapped queue, mispredict tag 7 rewinds tail to 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc(i);
      beu(i, 1'b0, '0); tick();
      commit_br_i = 1'b1; tick();
    end
    chk("t5_empty_at_6", 64'(empty_o), 64'd1);
    chk("t5_tail_at_6", 64'(alloc_tag_o), 64'd6);
    for (int k = 0; k < 4; k++) begin
      chk("t5_wrap_tag", 64'(alloc_tag_o), 64'((6 + k) % 8));
      alloc(46 + k);
    end
    beu(7, 1'b1, 32'h0000_5000);
    push_exp(32'h0000_5000, 7, 47);
    tick();
    chk("t5_rewound_tag", 64'(alloc_tag_o), 64'd0);
    chk("t5_pulse", 64'(redirect_valid_o), 64'd1);
    tick();
    chk("t5_ready", 64'(alloc_ready_o), 64'd1);
    beu(0, 1'b1, 32'h0000_6000);
    tick();
    chk("t5_freed_tag_dropped", 64'(redirect_valid_o), 64'd0);
    beu(6, 1'b0, '0); tick();
    commit_br_i = 1'b1; tick();
    chk("t5_count_one_left", 64'(empty_o), 64'd0);
    commit_br_i = 1'b1; tick();
    chk("t5_count_two_drained", 64'(empty_o), 64'd1);
    chk("t5_final_tail", 64'(alloc_tag_o), 64'd0);

    // 6: asynchronous reset in the FLUSH cycle
    do_reset();
    for (int i = 0; i < 3; i++) alloc(i);
    beu(0, 1'b1, 32'h0000_7000);
    tick();
    chk("t6_in_flush", 64'(redirect_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_redirect", 64'(redirect_valid_o), 64'd0);
    chk("t6_async_flush", 64'(flush_valid_o), 64'd0);
    chk("t6_async_empty", 64'(empty_o), 64'd1);
    chk("t6_async_tag", 64'(alloc_tag_o), 64'd0);
    chk("t6_async_pc", 64'(redirect_pc_o), 64'd0);
    chk("t6_async_ready", 64'(alloc_ready_o), 64'd1);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_pulse", 64'(redirect_valid_o), 64'd0);
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
